// File: rtl/clock_ctrl.sv
// BCD time-of-day clock with RUN / SET_HR / SET_MIN modes, blink blanking and set-mode timeout.
// Define CLOCK_CTRL_12H_EN for 12-hour operation (12,01..11 with pm flag); default is 24-hour.
module clock_ctrl #(
    parameter int TIMEOUT_TICKS = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_en,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] sec_lo,
    output logic [2:0] sec_hi,
    output logic [3:0] min_lo,
    output logic [2:0] min_hi,
    output logic [3:0] hr_lo,
    output logic [1:0] hr_hi,
    output logic       pm,
    output logic [1:0] mode,
    output logic       blank_hr,
    output logic       blank_min,
    output logic       day_co
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        BAD     = 2'd3
    } state_t;

    localparam int TO_W = (TIMEOUT_TICKS < 1) ? 1 : $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);

`ifdef CLOCK_CTRL_12H_EN
    localparam logic [1:0] HR_RST_HI = 2'd1;
    localparam logic [3:0] HR_RST_LO = 4'd2;
`else
    localparam logic [1:0] HR_RST_HI = 2'd0;
    localparam logic [3:0] HR_RST_LO = 4'd0;
`endif

    state_t          state;
    logic            blink;
    logic [TO_W-1:0] to_cnt;

    logic sec_wrap;
    logic min_wrap;
    logic hr_last;
    logic day_wrap;

    // Modulo-60 BCD increment shared by seconds and minutes: {hi, lo}
    function automatic logic [6:0] bcd60_inc(input logic [2:0] hi, input logic [3:0] lo);
        if (lo == 4'd9)
            return (hi == 3'd5) ? 7'd0 : {hi + 3'd1, 4'd0};
        else
            return {hi, lo + 4'd1};
    endfunction

    function automatic logic [5:0] hr_inc(input logic [1:0] hi, input logic [3:0] lo);
`ifdef CLOCK_CTRL_12H_EN
        if (hi == 2'd1 && lo == 4'd2)
            return {2'd0, 4'd1};
`else
        if (hi == 2'd2 && lo == 4'd3)
            return {2'd0, 4'd0};
`endif
        else if (lo == 4'd9)
            return {hi + 2'd1, 4'd0};
        else
            return {hi, lo + 4'd1};
    endfunction

    assign sec_wrap = (sec_hi == 3'd5) && (sec_lo == 4'd9);
    assign min_wrap = (min_hi == 3'd5) && (min_lo == 4'd9);
`ifdef CLOCK_CTRL_12H_EN
    // 11:59:59 is the last second before the 12 o'clock rollover that flips am/pm
    assign hr_last  = (hr_hi == 2'd1) && (hr_lo == 4'd1);
    assign day_wrap = sec_wrap && min_wrap && hr_last && pm;
`else
    assign hr_last  = (hr_hi == 2'd2) && (hr_lo == 4'd3);
    assign day_wrap = sec_wrap && min_wrap && hr_last;
`endif

    assign mode      = state;
    assign blank_hr  = (state == SET_HR) && blink;
    assign blank_min = (state == SET_MIN) && blink;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= RUN;
            blink  <= 1'b0;
            to_cnt <= '0;
            day_co <= 1'b0;
            sec_lo <= 4'd0;
            sec_hi <= 3'd0;
            min_lo <= 4'd0;
            min_hi <= 3'd0;
            hr_lo  <= HR_RST_LO;
            hr_hi  <= HR_RST_HI;
        end else begin
            day_co <= 1'b0;
            case (state)
                RUN: begin
                    if (tick_en) begin
                        {sec_hi, sec_lo} <= bcd60_inc(sec_hi, sec_lo);
                        if (sec_wrap) begin
                            {min_hi, min_lo} <= bcd60_inc(min_hi, min_lo);
                            if (min_wrap)
                                {hr_hi, hr_lo} <= hr_inc(hr_hi, hr_lo);
                        end
                        day_co <= day_wrap;
                    end
                    if (btn_mode) begin
                        state  <= SET_HR;
                        blink  <= 1'b0;
                        to_cnt <= '0;
                    end
                end
                SET_HR, SET_MIN: begin
                    if (btn_mode) begin
                        blink  <= 1'b0;
                        to_cnt <= '0;
                        if (state == SET_HR) begin
                            state <= SET_MIN;
                        end else begin
                            state  <= RUN;
                            sec_lo <= 4'd0;
                            sec_hi <= 3'd0;
                        end
                    end else begin
                        if (tick_en)
                            blink <= ~blink;
                        if (btn_inc) begin
                            to_cnt <= '0;
                            if (state == SET_HR)
                                {hr_hi, hr_lo} <= hr_inc(hr_hi, hr_lo);
                            else
                                {min_hi, min_lo} <= bcd60_inc(min_hi, min_lo);
                        end else if (tick_en) begin
                            // The tick that completes the idle window exits immediately
                            if (to_cnt >= TO_LAST) begin
                                state  <= RUN;
                                blink  <= 1'b0;
                                to_cnt <= '0;
                                sec_lo <= 4'd0;
                                sec_hi <= 3'd0;
                            end else begin
                                to_cnt <= to_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state  <= RUN;
                    blink  <= 1'b0;
                    to_cnt <= '0;
                end
            endcase
        end
    end

`ifdef CLOCK_CTRL_12H_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pm <= 1'b0;
        else if (state == RUN && tick_en && sec_wrap && min_wrap && hr_last)
            pm <= ~pm;
    end
`else
    assign pm = 1'b0;
`endif

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed testbench for clock_ctrl in the default 24-hour build.
module tb_clock_ctrl;

    localparam int TO = 30;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_en = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] sec_lo;
    logic [2:0] sec_hi;
    logic [3:0] min_lo;
    logic [2:0] min_hi;
    logic [3:0] hr_lo;
    logic [1:0] hr_hi;
    logic       pm;
    logic [1:0] mode;
    logic       blank_hr;
    logic       blank_min;
    logic       day_co;

    int n_checks = 0;
    int n_fail   = 0;

    clock_ctrl #(.TIMEOUT_TICKS(TO)) dut (
        .clk(clk), .rst(rst), .tick_en(tick_en), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .sec_lo(sec_lo), .sec_hi(sec_hi), .min_lo(min_lo), .min_hi(min_hi),
        .hr_lo(hr_lo), .hr_hi(hr_hi), .pm(pm), .mode(mode),
        .blank_hr(blank_hr), .blank_min(blank_min), .day_co(day_co)
    );

    always #5 clk = ~clk;

    logic [19:0] tm;
    assign tm = {hr_hi, hr_lo, min_hi, min_lo, sec_hi, sec_lo};

    function automatic logic [19:0] tpack(input int h, input int m, input int s);
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
    endfunction

    // One clock cycle with the given inputs; returns 1 time unit after the edge.
    task automatic cyc(input logic t, input logic m, input logic i);
        tick_en  = t;
        btn_mode = m;
        btn_inc  = i;
        @(posedge clk);
        #1;
        tick_en  = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_checks++;
        if (tm !== tpack(0, 0, 0) || mode !== 2'd0 || pm !== 1'b0 || day_co !== 1'b0 ||
            blank_hr !== 1'b0 || blank_min !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: time=%h mode=%0d pm=%b dco=%b bh=%b bm=%b, want time=%h all zero",
                     tm, mode, pm, day_co, blank_hr, blank_min, tpack(0, 0, 0));
        end
        do_reset();
    endtask

    task automatic test_count();
        do_reset();
        for (int k = 0; k < 61; k++) cyc(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (tm !== tpack(0, 1, 1)) begin
            n_fail++;
            $display("FAIL count_61: got %h want %h", tm, tpack(0, 1, 1));
        end
        cyc(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (tm !== tpack(0, 1, 1) || mode !== 2'd0) begin
            n_fail++;
            $display("FAIL inc_in_run: got %h mode %0d want %h mode 0", tm, mode, tpack(0, 1, 1));
        end
    endtask

    task automatic test_set_preload();
        do_reset();
        for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (mode !== 2'd1) begin
            n_fail++;
            $display("FAIL enter_set_hr: mode %0d want 1", mode);
        end
        for (int k = 0; k < 25; k++) cyc(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (tm !== tpack(1, 0, 5)) begin
            n_fail++;
            $display("FAIL hr_inc_wrap: got %h want %h", tm, tpack(1, 0, 5));
        end
        cyc(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 61; k++) cyc(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (tm !== tpack(1, 1, 5) || mode !== 2'd2) begin
            n_fail++;
            $display("FAIL min_inc_wrap: got %h mode %0d want %h mode 2", tm, mode, tpack(1, 1, 5));
        end
        cyc(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (tm !== tpack(1, 1, 0) || mode !== 2'd0) begin
            n_fail++;
            $display("FAIL set_exit: got %h mode %0d want %h mode 0", tm, mode, tpack(1, 1, 0));
        end
    endtask

    task automatic test_day_wrap();
        do_reset();
        cyc(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 23; k++) cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 59; k++) cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 58; k++) cyc(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (tm !== tpack(23, 59, 58)) begin
            n_fail++;
            $display("FAIL preload_235958: got %h want %h", tm, tpack(23, 59, 58));
        end
        cyc(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (tm !== tpack(23, 59, 59) || day_co !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_wrap: got %h dco %b want %h dco 0", tm, day_co, tpack(23, 59, 59));
        end
        cyc(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (tm !== tpack(0, 0, 0) || day_co !== 1'b1) begin
            n_fail++;
            $display("FAIL day_wrap: got %h dco %b want %h dco 1", tm, day_co, tpack(0, 0, 0));
        end
        cyc(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (day_co !== 1'b0) begin
            n_fail++;
            $display("FAIL day_co_width: dco %b want 0", day_co);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= TO; k++) begin
            cyc(1'b1, 1'b0, 1'b0);
            n_checks++;
            if (k < TO) begin
                if (mode !== 2'd1 || blank_hr !== 1'(k % 2) || tm !== tpack(0, 0, 3)) begin
                    n_fail++;
                    $display("FAIL set_hr_tick%0d: mode %0d bh %b time %h want mode 1 bh %0d time %h",
                             k, mode, blank_hr, tm, k % 2, tpack(0, 0, 3));
                end
            end else begin
                if (mode !== 2'd0 || blank_hr !== 1'b0 || tm !== tpack(0, 0, 0)) begin
                    n_fail++;
                    $display("FAIL timeout_exit: mode %0d bh %b time %h want mode 0 bh 0 time %h",
                             mode, blank_hr, tm, tpack(0, 0, 0));
                end
            end
        end
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < TO - 1; k++) cyc(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (mode !== 2'd2 || blank_min !== 1'b1 || tm !== tpack(0, 1, 0)) begin
            n_fail++;
            $display("FAIL inc_restarts_timeout: mode %0d bm %b time %h want mode 2 bm 1 time %h",
                     mode, blank_min, tm, tpack(0, 1, 0));
        end
        cyc(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (mode !== 2'd0) begin
            n_fail++;
            $display("FAIL set_min_timeout: mode %0d want 0", mode);
        end
    endtask

    task automatic test_collisions();
        do_reset();
        cyc(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (tm !== tpack(0, 0, 1) || mode !== 2'd1) begin
            n_fail++;
            $display("FAIL tick_and_mode: got %h mode %0d want %h mode 1", tm, mode, tpack(0, 0, 1));
        end
        do_reset();
        cyc(1'b0, 1'b1, 1'b1);
        n_checks++;
        if (tm !== tpack(0, 0, 0) || mode !== 2'd1) begin
            n_fail++;
            $display("FAIL mode_beats_inc: got %h mode %0d want %h mode 1", tm, mode, tpack(0, 0, 0));
        end
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (tm !== tpack(0, 0, 0) || mode !== 2'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %h mode %0d want %h mode 0", tm, mode, tpack(0, 0, 0));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (tm !== tpack(0, 0, 1) || mode !== 2'd0) begin
            n_fail++;
            $display("FAIL first_tick_after_reset: got %h mode %0d want %h mode 0",
                     tm, mode, tpack(0, 0, 1));
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_set_preload();
        test_day_wrap();
        test_timeout();
        test_collisions();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
